// File: rtl/fe_branch_predictor.sv
// fe_branch_predictor
//   Fetch-side branch predictor built from a direct-mapped branch target
//   buffer (BTB) and a pattern history table (PHT) of 2-bit saturating
//   counters. A lookup is purely combinational, so the predicted next fetch PC
//   is available in the same cycle as the fetch PC. The global history
//   register (BHR) is shifted speculatively on conditional-branch hits.
//   Each lookup's BHR snapshot is exported so it can travel down the pipe.
//   When AGEX resolves a branch, the snapshot comes back with the update so
//   the PHT entry and the history can be repaired.
//
// Configuration macro:
//   GSHARE_EN  defined   -> PHT index is PC bits XOR zero-extended history
//              undefined -> bimodal PHT index from PC bits only; BHR is still
//                           maintained and exported so the ports do not change
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_fe_valid           fetch lookup valid this cycle
//   i_fe_stall           fetch stalled; suppresses the speculative BHR shift
//   i_fe_pc              fetch PC (word-aligned)
//   o_pred_taken         predicted taken
//   o_pred_next_pc       predicted next fetch PC
//   o_pred_bhr           BHR value used for this lookup
//   i_upd_valid          AGEX resolution valid (branches and jumps only)
//   i_upd_is_cond        1 = conditional branch, 0 = JAL/JALR
//   i_upd_pc             PC of the resolved instruction
//   i_upd_taken          actual direction (1 for jumps)
//   i_upd_target         actual target
//   i_upd_bhr            BHR snapshot returned with the instruction
//   i_upd_mispred        AGEX mispredict flag
//   o_stat_mispred       running count of mispredict updates (wraps)

module fe_branch_predictor #(
  parameter int DBITS        = 32,
  parameter int BTB_IDX_BITS = 4,
  parameter int PHT_IDX_BITS = 6,
  parameter int BHR_BITS     = 6
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_fe_valid,
  input  logic                i_fe_stall,
  input  logic [DBITS-1:0]    i_fe_pc,
  output logic                o_pred_taken,
  output logic [DBITS-1:0]    o_pred_next_pc,
  output logic [BHR_BITS-1:0] o_pred_bhr,
  input  logic                i_upd_valid,
  input  logic                i_upd_is_cond,
  input  logic [DBITS-1:0]    i_upd_pc,
  input  logic                i_upd_taken,
  input  logic [DBITS-1:0]    i_upd_target,
  input  logic [BHR_BITS-1:0] i_upd_bhr,
  input  logic                i_upd_mispred,
  output logic [31:0]         o_stat_mispred
);

  localparam int TAG_BITS    = DBITS - BTB_IDX_BITS - 2;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;

  logic                    r_btbValid [BTB_ENTRIES];
  logic                    r_btbUnc   [BTB_ENTRIES];
  logic [TAG_BITS-1:0]     r_btbTag   [BTB_ENTRIES];
  logic [DBITS-1:0]        r_btbTgt   [BTB_ENTRIES];
  logic [1:0]              r_pht      [PHT_ENTRIES];
  logic [BHR_BITS-1:0]     r_bhr;
  logic [31:0]             r_statMispred;

  logic [BTB_IDX_BITS-1:0] w_lookupBidx;
  logic [TAG_BITS-1:0]     w_lookupTag;
  logic [PHT_IDX_BITS-1:0] w_lookupPidx;
  logic                    w_lookupHit;
  logic                    w_lookupUnc;
  logic                    w_bhrShift;
  logic [BTB_IDX_BITS-1:0] w_updBidx;
  logic [TAG_BITS-1:0]     w_updTag;
  logic [PHT_IDX_BITS-1:0] w_updPidx;
  logic                    w_updRecover;
  logic                    w_unusedUpdPcBits;

  // Word-aligned PCs: the two low bits of the update PC never select anything.
  assign w_unusedUpdPcBits = ^i_upd_pc[1:0];

  assign w_lookupBidx = i_fe_pc[BTB_IDX_BITS+1:2];
  assign w_lookupTag  = i_fe_pc[DBITS-1:BTB_IDX_BITS+2];
  assign w_updBidx    = i_upd_pc[BTB_IDX_BITS+1:2];
  assign w_updTag     = i_upd_pc[DBITS-1:BTB_IDX_BITS+2];

  // The update index must be formed the same way as the lookup index.
  // The returned snapshot stands in for the history that was live at fetch.
`ifdef GSHARE_EN
  assign w_lookupPidx = i_fe_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(r_bhr);
  assign w_updPidx    = i_upd_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(i_upd_bhr);
`else
  assign w_lookupPidx = i_fe_pc[PHT_IDX_BITS+1:2];
  assign w_updPidx    = i_upd_pc[PHT_IDX_BITS+1:2];
`endif

  // Zero-cycle lookup against the table contents as they stand before the
  // clock edge. Unconditional jumps are always taken once they are in the BTB.
  assign w_lookupHit    = r_btbValid[w_lookupBidx] && (r_btbTag[w_lookupBidx] == w_lookupTag);
  assign w_lookupUnc    = r_btbUnc[w_lookupBidx];
  assign o_pred_taken   = i_fe_valid && !i_reset && w_lookupHit &&
                          (w_lookupUnc || r_pht[w_lookupPidx][1]);
  assign o_pred_next_pc = o_pred_taken ? r_btbTgt[w_lookupBidx] : (i_fe_pc + DBITS'(4));
  assign o_pred_bhr     = r_bhr;
  assign o_stat_mispred = r_statMispred;

  // Only conditional-branch hits feed the history; jumps carry no direction
  // information worth remembering.
  assign w_bhrShift   = i_fe_valid && !i_fe_stall && w_lookupHit && !w_lookupUnc;
  assign w_updRecover = i_upd_valid && i_upd_mispred;

  // The history register and the mispredict counter.
  // On recovery the snapshot is restored. For a conditional branch, the
  // branch's true outcome is appended, as the speculative shift would have.
  // Recovery overrides any shift from the concurrent lookup.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bhr         <= '0;
      r_statMispred <= '0;
    end else begin
      if (w_updRecover) begin
        r_bhr         <= i_upd_is_cond ? {i_upd_bhr[BHR_BITS-2:0], i_upd_taken} : i_upd_bhr;
        r_statMispred <= r_statMispred + 32'd1;
      end else if (w_bhrShift) begin
        r_bhr <= {r_bhr[BHR_BITS-2:0], o_pred_taken};
      end
    end
  end

  // BTB valid bits and PHT counters.
  // Reset clears every valid bit and sets every counter to weakly not-taken.
  // Counters saturate at both ends so one outlier does not flip a strong bias.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btbValid[i] <= 1'b0;
      end
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else begin
      if (i_upd_valid && i_upd_taken) begin
        r_btbValid[w_updBidx] <= 1'b1;
      end
      if (i_upd_valid && i_upd_is_cond) begin
        if (i_upd_taken) begin
          if (r_pht[w_updPidx] != 2'b11) begin
            r_pht[w_updPidx] <= r_pht[w_updPidx] + 2'd1;
          end
        end else begin
          if (r_pht[w_updPidx] != 2'b00) begin
            r_pht[w_updPidx] <= r_pht[w_updPidx] - 2'd1;
          end
        end
      end
    end
  end

  // BTB payload: tag, target and the unconditional flag.
  // The valid bit alone qualifies an entry, so this payload needs no reset.
  // A not-taken branch leaves the BTB untouched, so a taken target it
  // learned earlier is kept.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_upd_valid && i_upd_taken) begin
      r_btbTag[w_updBidx] <= w_updTag;
      r_btbTgt[w_updBidx] <= i_upd_target;
      r_btbUnc[w_updBidx] <= !i_upd_is_cond;
    end
  end

endmodule

// File: tb/tb_fe_branch_predictor.sv
// tb_fe_branch_predictor
//   Directed bench for fe_branch_predictor in its default bimodal build.
//   Each scenario drives lookups and resolution updates. It then compares
//   the prediction outputs, the history snapshot and the mispredict counter
//   against values worked out by hand.

module tb_fe_branch_predictor;

  logic        clk;
  logic        reset;
  logic        feValid;
  logic        feStall;
  logic [31:0] fePc;
  logic        predTaken;
  logic [31:0] predNextPc;
  logic [5:0]  predBhr;
  logic        updValid;
  logic        updIsCond;
  logic [31:0] updPc;
  logic        updTaken;
  logic [31:0] updTarget;
  logic [5:0]  updBhr;
  logic        updMispred;
  logic [31:0] statMispred;

  int checkCount;
  int failCount;

  fe_branch_predictor dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_fe_valid     (feValid),
    .i_fe_stall     (feStall),
    .i_fe_pc        (fePc),
    .o_pred_taken   (predTaken),
    .o_pred_next_pc (predNextPc),
    .o_pred_bhr     (predBhr),
    .i_upd_valid    (updValid),
    .i_upd_is_cond  (updIsCond),
    .i_upd_pc       (updPc),
    .i_upd_taken    (updTaken),
    .i_upd_target   (updTarget),
    .i_upd_bhr      (updBhr),
    .i_upd_mispred  (updMispred),
    .o_stat_mispred (statMispred)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance past the next rising edge and stop 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a lookup and let the combinational outputs settle.
  task automatic applyStimulus(input logic [31:0] pc, input logic stall);
    fePc    = pc;
    feStall = stall;
    #1;
  endtask

  task automatic setUpdate(input logic isCond, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic [5:0] bhr, input logic mispred);
    updValid   = 1'b1;
    updIsCond  = isCond;
    updPc      = pc;
    updTaken   = taken;
    updTarget  = tgt;
    updBhr     = bhr;
    updMispred = mispred;
  endtask

  task automatic clearUpdate();
    updValid   = 1'b0;
    updIsCond  = 1'b0;
    updPc      = '0;
    updTaken   = 1'b0;
    updTarget  = '0;
    updBhr     = '0;
    updMispred = 1'b0;
  endtask

  // One update, applied across a single clock edge and then withdrawn.
  task automatic doUpdate(input logic isCond, input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic [5:0] bhr, input logic mispred);
    setUpdate(isCond, pc, taken, tgt, bhr, mispred);
    tick();
    clearUpdate();
    #1;
  endtask

  // Safety net so a hung run still ends with a verdict.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got 0x1 expected 0x0");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset      = 1'b1;
    feValid    = 1'b1;
    feStall    = 1'b1;
    fePc       = 32'h100;
    clearUpdate();
    tick();
    tick();

    // While reset is held, no prediction is made.
    checkOutput("rst_taken", {31'd0, predTaken}, 32'd0);
    checkOutput("rst_next", predNextPc, 32'h104);
    checkOutput("rst_stat", statMispred, 32'd0);

    // First lookup after reset misses.
    reset = 1'b0;
    #1;
    checkOutput("t1_taken", {31'd0, predTaken}, 32'd0);
    checkOutput("t1_next", predNextPc, 32'h104);
    checkOutput("t1_bhr", {26'd0, predBhr}, 32'd0);

    // A taken update is not visible to a lookup in the same cycle.
    // From the next cycle the counter is 10 and the lookup predicts taken.
    setUpdate(1'b1, 32'h100, 1'b1, 32'h40, 6'd0, 1'b0);
    #1;
    checkOutput("t2_nobypass", {31'd0, predTaken}, 32'd0);
    tick();
    clearUpdate();
    #1;
    checkOutput("t2_taken", {31'd0, predTaken}, 32'd1);
    checkOutput("t2_next", predNextPc, 32'h40);

    // Three more taken updates saturate the counter at 11.
    // Two not-taken updates then bring it to 10 and finally to 01.
    for (int i = 0; i < 3; i++) begin
      doUpdate(1'b1, 32'h100, 1'b1, 32'h40, 6'd0, 1'b0);
    end
    checkOutput("t3_sat_taken", {31'd0, predTaken}, 32'd1);
    doUpdate(1'b1, 32'h100, 1'b0, 32'h0, 6'd0, 1'b0);
    checkOutput("t3_nt1_taken", {31'd0, predTaken}, 32'd1);
    doUpdate(1'b1, 32'h100, 1'b0, 32'h0, 6'd0, 1'b0);
    checkOutput("t3_nt2_taken", {31'd0, predTaken}, 32'd0);
    checkOutput("t3_nt2_next", predNextPc, 32'h104);

    // A JAL is predicted taken even though its PHT slot holds 01.
    // The lookup does not shift the history.
    doUpdate(1'b0, 32'h200, 1'b1, 32'h300, 6'd0, 1'b0);
    applyStimulus(32'h200, 1'b0);
    checkOutput("t4_taken", {31'd0, predTaken}, 32'd1);
    checkOutput("t4_next", predNextPc, 32'h300);
    tick();
    checkOutput("t4_noshift", {26'd0, predBhr}, 32'd0);
    feStall = 1'b1;

    // A conditional hit and a mispredict update land in the same cycle.
    // Recovery wins: 000101 gets outcome 0 appended.
    doUpdate(1'b1, 32'h104, 1'b1, 32'h80, 6'd0, 1'b0);
    applyStimulus(32'h104, 1'b0);
    checkOutput("t5_taken", {31'd0, predTaken}, 32'd1);
    checkOutput("t5_next", predNextPc, 32'h80);
    setUpdate(1'b1, 32'h180, 1'b0, 32'h0, 6'b000101, 1'b1);
    tick();
    clearUpdate();
    feStall = 1'b1;
    #1;
    checkOutput("t5_recover_bhr", {26'd0, predBhr}, 32'h0a);
    checkOutput("t5_stat", statMispred, 32'd1);

    // A plain speculative shift, then a stall, then a miss.
    // Only the first of these changes the history.
    applyStimulus(32'h104, 1'b0);
    tick();
    feStall = 1'b1;
    #1;
    checkOutput("t5_shift_bhr", {26'd0, predBhr}, 32'h15);
    tick();
    checkOutput("t5_stall_bhr", {26'd0, predBhr}, 32'h15);
    applyStimulus(32'h300, 1'b0);
    checkOutput("t5_miss_next", predNextPc, 32'h304);
    tick();
    feStall = 1'b1;
    #1;
    checkOutput("t5_miss_bhr", {26'd0, predBhr}, 32'h15);

    // A mispredicted jump restores the snapshot as-is.
    doUpdate(1'b0, 32'h208, 1'b1, 32'h400, 6'b110011, 1'b1);
    checkOutput("t5_jal_bhr", {26'd0, predBhr}, 32'h33);
    checkOutput("t5_jal_stat", statMispred, 32'd2);
    applyStimulus(32'h208, 1'b1);
    checkOutput("t5_jal_next", predNextPc, 32'h400);

    // The 0x180 counter already sits at 00 and must not wrap downward.
    // One taken update brings it to 01, which predicts not-taken.
    doUpdate(1'b1, 32'h180, 1'b0, 32'h0, 6'd0, 1'b0);
    doUpdate(1'b1, 32'h180, 1'b1, 32'h500, 6'd0, 1'b0);
    applyStimulus(32'h180, 1'b1);
    checkOutput("sat_low_taken", {31'd0, predTaken}, 32'd0);
    checkOutput("sat_low_next", predNextPc, 32'h184);

    // Addresses 0x100 and 0x140 share BTB slot 0, so the later write evicts
    // the earlier one.
    doUpdate(1'b1, 32'h100, 1'b1, 32'h40, 6'd0, 1'b0);
    doUpdate(1'b1, 32'h140, 1'b1, 32'h44, 6'd0, 1'b0);
    applyStimulus(32'h100, 1'b1);
    checkOutput("t6_evicted_taken", {31'd0, predTaken}, 32'd0);
    checkOutput("t6_evicted_next", predNextPc, 32'h104);
    applyStimulus(32'h140, 1'b1);
    checkOutput("t6_alias_next", predNextPc, 32'h44);

    // Reset mid-run: an update presented during reset is dropped.
    // Afterwards every table entry is empty and the counters are cleared.
    setUpdate(1'b1, 32'h104, 1'b1, 32'h80, 6'd3, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("t6_inrst_taken", {31'd0, predTaken}, 32'd0);
    checkOutput("t6_inrst_next", predNextPc, 32'h144);
    tick();
    reset = 1'b0;
    clearUpdate();
    #1;
    checkOutput("t6_rst_stat", statMispred, 32'd0);
    checkOutput("t6_rst_bhr", {26'd0, predBhr}, 32'd0);
    checkOutput("t6_rst_next140", predNextPc, 32'h144);
    applyStimulus(32'h104, 1'b1);
    checkOutput("t6_rst_next104", predNextPc, 32'h108);
    applyStimulus(32'h208, 1'b1);
    checkOutput("t6_rst_next208", predNextPc, 32'h20c);
    doUpdate(1'b1, 32'h140, 1'b1, 32'h44, 6'd0, 1'b0);
    applyStimulus(32'h140, 1'b1);
    checkOutput("t6_relearn_next", predNextPc, 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
